// File: rtl/image_write_sequencer_if.sv
// image_write_sequencer_if
// Groups the frame-control, pixel input and writer-side output signals of the
// image write sequencer into one bundle.
//   start       : single-cycle frame start request (pipeline -> sequencer)
//   in_valid    : in_data holds a valid pixel pair
//   in_ready    : sequencer accepts in_data this cycle
//   in_data     : {R0,G0,B0,R1,G1,B1}, R0 at [47:40], B1 at [7:0]
//   out_hsync   : out_data is valid for the BMP writer this cycle
//   out_data    : pixel pair to the writer, same packing as in_data
//   row_index   : row of the pair currently on out_data
//   col_index   : pair column of the pair currently on out_data
//   busy        : frame in progress
//   frame_done  : one-cycle pulse after the last pair of a frame
// The master modport is the side that drives the sequencer (pipeline);
// the slave modport is the sequencer itself.
interface image_write_sequencer_if #(
  parameter int WIDTH  = 768,
  parameter int HEIGHT = 512
) ();

  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = ((WIDTH / 2) > 1) ? $clog2(WIDTH / 2) : 1;

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [47:0]      in_data;
  logic             out_hsync;
  logic [47:0]      out_data;
  logic [ROW_W-1:0] row_index;
  logic [COL_W-1:0] col_index;
  logic             busy;
  logic             frame_done;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, out_hsync, out_data, row_index, col_index, busy, frame_done
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, out_hsync, out_data, row_index, col_index, busy, frame_done
  );

endinterface

// File: rtl/image_write_sequencer.sv
// image_write_sequencer
// Sequences one frame of pixel pairs from the processing pipeline into the BMP
// image writer. Pairs are accepted on a valid/ready handshake into a small
// FIFO and replayed as an HSYNC-qualified stream, with programmable blanking
// between rows and a frame_done pulse after the final pair.
// Ports:
//   HCLK    : clock, all logic on the rising edge
//   HRESET  : asynchronous active-high reset (release synchronised to HCLK)
//   bus     : image_write_sequencer_if.slave (start, in_valid/in_ready/in_data,
//             out_hsync/out_data, row_index, col_index, busy, frame_done)
module image_write_sequencer #(
  parameter int WIDTH         = 768,
  parameter int HEIGHT        = 512,
  parameter int HBLANK_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  image_write_sequencer_if.slave  bus
);

  localparam int PAIRS_PER_ROW = WIDTH / 2;
  localparam int TOTAL_PAIRS   = PAIRS_PER_ROW * HEIGHT;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (PAIRS_PER_ROW > 1) ? $clog2(PAIRS_PER_ROW) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ACC_W = $clog2(TOTAL_PAIRS + 1);
  localparam int HB_W  = (HBLANK_CYCLES > 0) ? $clog2(HBLANK_CYCLES + 1) : 1;

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(PAIRS_PER_ROW - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [ACC_W-1:0] ACC_LIMIT = ACC_W'(TOTAL_PAIRS);
  localparam logic [HB_W-1:0]  HB_LAST   = HB_W'((HBLANK_CYCLES > 0) ? HBLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_DONE
  } state_t;

  state_t           state;
  logic [1:0]       rst_pipe;
  logic             rst;

  logic [47:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [ACC_W-1:0] accepted;

  // Position of the next pair to be emitted; copied into row_q/col_q on emit
  // so the outputs describe the pair actually on out_data.
  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;
  logic [HB_W-1:0]  hb_cnt;

  logic             out_hsync_q;
  logic [47:0]      out_data_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic             busy_q;
  logic             done_q;

  logic             in_ready_w;
  logic             push;
  logic             pop;

  // Reset asserts immediately but is released only after two clean HCLK edges
  // so no flop sees reset removal near an active edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst = rst_pipe[1];

  // Slot availability uses the registered count only: a pop in this cycle
  // frees its slot for the next cycle, keeping in_ready free of output paths.
  assign in_ready_w = ((state == S_ACTIVE) || (state == S_HBLANK)) &&
                      (count != FIFO_FULL) && (accepted < ACC_LIMIT);
  assign push = bus.in_valid && in_ready_w;
  assign pop  = (state == S_ACTIVE) && (count != '0);

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_data;
    end
  end

  // Single FSM block: FIFO bookkeeping, position counters, row blanking and
  // the registered writer-side outputs all advance together.
  always_ff @(posedge HCLK or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      accepted    <= '0;
      nxt_col     <= '0;
      nxt_row     <= '0;
      hb_cnt      <= '0;
      out_hsync_q <= 1'b0;
      out_data_q  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        accepted <= accepted + 1'b1;
      end
      if (pop) begin
        rd_ptr     <= rd_ptr + 1'b1;
        out_data_q <= mem[rd_ptr];
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end

      out_hsync_q <= pop;
      done_q      <= 1'b0;

      case (state)
        S_IDLE: begin
          busy_q <= bus.start;
          if (bus.start) begin
            state    <= S_ACTIVE;
            accepted <= '0;
            nxt_col  <= '0;
            nxt_row  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            hb_cnt   <= '0;
          end
        end

        S_ACTIVE: begin
          busy_q <= 1'b1;
          if (pop) begin
            row_q <= nxt_row;
            col_q <= nxt_col;
            if (nxt_col == COL_LAST) begin
              nxt_col <= '0;
              if (nxt_row == ROW_LAST) begin
                nxt_row <= '0;
                state   <= S_DONE;
              end else begin
                nxt_row <= nxt_row + 1'b1;
                if (HBLANK_CYCLES > 0) begin
                  hb_cnt <= '0;
                  state  <= S_HBLANK;
                end
              end
            end else begin
              nxt_col <= nxt_col + 1'b1;
            end
          end
        end

        S_HBLANK: begin
          busy_q <= 1'b1;
          if (hb_cnt == HB_LAST) begin
            hb_cnt <= '0;
            state  <= S_ACTIVE;
          end else begin
            hb_cnt <= hb_cnt + 1'b1;
          end
        end

        S_DONE: begin
          // frame_done lands the cycle after the last pair; busy drops one
          // cycle later so the writer sees busy cover the pulse.
          busy_q <= 1'b1;
          done_q <= 1'b1;
          row_q  <= '0;
          col_q  <= '0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.out_hsync  = out_hsync_q;
  assign bus.out_data   = out_data_q;
  assign bus.row_index  = row_q;
  assign bus.col_index  = col_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_image_write_sequencer.sv
// tb_image_write_sequencer
// Self-checking bench for image_write_sequencer on a small 8x4 frame.
// The driver pushes every accepted pair, tagged with its frame position, into
// a scoreboard queue; a monitor on the falling edge pops and compares each
// out_hsync pair and checks row gaps, frame_done/busy timing and full-FIFO
// backpressure. A second instance with zero blanking checks gap-free output.
module tb_image_write_sequencer;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int HB    = 2;
  localparam int FD    = 4;
  localparam int COLS  = W / 2;
  localparam int PAIRS = COLS * H;

  typedef struct {
    logic [47:0] data;
    int          row;
    int          col;
  } exp_t;

  logic HCLK = 1'b0;
  logic HRESET;

  always #5 HCLK = ~HCLK;

  image_write_sequencer_if #(.WIDTH(W), .HEIGHT(H)) bus ();
  image_write_sequencer_if #(.WIDTH(W), .HEIGHT(H)) bus0 ();

  image_write_sequencer #(
    .WIDTH(W), .HEIGHT(H), .HBLANK_CYCLES(HB), .FIFO_DEPTH(FD)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus)
  );

  image_write_sequencer #(
    .WIDTH(W), .HEIGHT(H), .HBLANK_CYCLES(0), .FIFO_DEPTH(FD)
  ) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .bus(bus0)
  );

  exp_t        sbq[$];
  exp_t        mon_e;
  int          mon_gap;
  int          errors = 0;
  int          checks = 0;
  int          cycle = 0;
  int          lastPulseCycle = -100;
  int          doneCycle = -100;
  int          emittedInFrame = 0;
  int          acceptedInFrame = 0;
  int          accTotal = 0;
  int          emTotal = 0;
  int          doneCount = 0;
  bit          frameRunning = 1'b0;
  bit          exactGaps = 1'b0;
  logic [47:0] lastData = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, actual, required, cycle);
    end
  endtask

  // Monitor: compares what the DUT presents against the scoreboard and the
  // frame timing rules.
  always @(negedge HCLK) begin
    cycle++;
    if (!HRESET) begin
      if (bus.out_hsync === 1'b1) begin
        if (sbq.size() == 0) begin
          checkOutput("hsync_without_pending_pair", 64'(1), 64'(0));
        end else begin
          mon_e = sbq.pop_front();
          checkOutput("out_data", 64'(bus.out_data), 64'(mon_e.data));
          checkOutput("row_index", 64'(bus.row_index), 64'(mon_e.row));
          checkOutput("col_index", 64'(bus.col_index), 64'(mon_e.col));
          if (emittedInFrame > 0) begin
            mon_gap = cycle - lastPulseCycle;
            if ((emittedInFrame % COLS) == 0) begin
              if (exactGaps) checkOutput("row_gap", 64'(mon_gap), 64'(HB + 1));
              else checkOutput("row_gap_min", 64'(mon_gap >= HB + 1), 64'(1));
            end else if (exactGaps) begin
              checkOutput("pair_gap", 64'(mon_gap), 64'(1));
            end
          end
          emittedInFrame++;
          emTotal++;
          lastPulseCycle = cycle;
          lastData = mon_e.data;
        end
      end else begin
        checkOutput("out_data_hold", 64'(bus.out_data), 64'(lastData));
      end

      if (frameRunning && emittedInFrame > 0)
        checkOutput("busy_in_frame", 64'(bus.busy), 64'(1));

      if (bus.frame_done === 1'b1) begin
        checkOutput("frame_done_timing",
                    64'(emittedInFrame == PAIRS && cycle == lastPulseCycle + 1), 64'(1));
        doneCount++;
        doneCycle = cycle;
        emittedInFrame = 0;
        frameRunning = 1'b0;
      end else if (emittedInFrame == PAIRS && cycle == lastPulseCycle + 1) begin
        checkOutput("frame_done_missing", 64'(bus.frame_done), 64'(1));
      end

      if (cycle == doneCycle + 1)
        checkOutput("busy_after_done", 64'(bus.busy), 64'(0));

      if (accTotal - emTotal == FD)
        checkOutput("in_ready_when_full", 64'(bus.in_ready), 64'(0));
      if (acceptedInFrame == PAIRS)
        checkOutput("in_ready_after_frame", 64'(bus.in_ready), 64'(0));
    end
  end

  // One driver cycle: present inputs on the falling edge, then decide whether
  // the coming rising edge transfers a pair and record the expectation.
  task automatic applyStimulus(input bit v, input bit st, input bit rnd);
    logic [47:0] d;
    @(negedge HCLK);
    if (rnd) begin
      d[47:32] = 16'($urandom_range(65535));
      d[31:0]  = $urandom;
    end else begin
      d = 48'(acceptedInFrame);
    end
    bus.in_valid = v;
    bus.in_data  = d;
    bus.start    = st;
    if (st && !frameRunning) begin
      frameRunning = 1'b1;
      acceptedInFrame = 0;
    end
    #1;
    if (v && bus.in_ready) begin
      checkOutput("transfer_within_frame",
                  64'(frameRunning && acceptedInFrame < PAIRS), 64'(1));
      sbq.push_back('{d, acceptedInFrame / COLS, acceptedInFrame % COLS});
      acceptedInFrame++;
      accTotal++;
    end
  endtask

  task automatic doReset();
    @(negedge HCLK);
    HRESET = 1'b1;
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.start = 1'b0;
    #1;
    checkOutput("rst_out_hsync", 64'(bus.out_hsync), 64'(0));
    checkOutput("rst_out_data", 64'(bus.out_data), 64'(0));
    checkOutput("rst_row_index", 64'(bus.row_index), 64'(0));
    checkOutput("rst_col_index", 64'(bus.col_index), 64'(0));
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_frame_done", 64'(bus.frame_done), 64'(0));
    checkOutput("rst_in_ready", 64'(bus.in_ready), 64'(0));
    sbq.delete();
    accTotal = 0;
    emTotal = 0;
    emittedInFrame = 0;
    acceptedInFrame = 0;
    frameRunning = 1'b0;
    lastPulseCycle = -100;
    doneCycle = -100;
    lastData = '0;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    repeat (4) @(negedge HCLK);
  endtask

  // Runs one frame on the main DUT; optional mid-frame start pulse after
  // midStartAt pairs, optional reset after resetAt pairs.
  task automatic runFrame(input int validPct, input bit rnd, input bit gapsExact,
                          input int midStartAt, input int resetAt);
    int startDone;
    bit midDone;
    bit st;
    bit v;
    startDone = doneCount;
    midDone = 1'b0;
    exactGaps = gapsExact;
    applyStimulus(1'b0, 1'b1, rnd);
    for (int c = 0; c < 3000; c++) begin
      if (doneCount != startDone) break;
      if (resetAt > 0 && emittedInFrame >= resetAt) begin
        doReset();
        return;
      end
      st = (midStartAt > 0 && !midDone && emittedInFrame == midStartAt);
      if (st) midDone = 1'b1;
      v = ($urandom_range(99) < validPct);
      applyStimulus(v, st, rnd);
    end
    checkOutput("frame_completed", 64'(doneCount - startDone), 64'(1));
    repeat (4) applyStimulus(1'b1, 1'b0, rnd);
  endtask

  task automatic zeroBlankFrame();
    int pulses;
    int prev;
    int acc;
    int dones;
    pulses = 0;
    prev = 0;
    acc = 0;
    dones = 0;
    @(negedge HCLK);
    bus0.start = 1'b1;
    bus0.in_valid = 1'b0;
    @(negedge HCLK);
    bus0.start = 1'b0;
    bus0.in_valid = 1'b1;
    bus0.in_data = 48'(acc);
    for (int c = 0; c < 200 && dones == 0; c++) begin
      #1;
      if (bus0.in_ready) acc++;
      @(negedge HCLK);
      if (bus0.out_hsync) begin
        checkOutput("zb_data", 64'(bus0.out_data), 64'(pulses));
        if (pulses > 0) checkOutput("zb_gap", 64'(c - prev), 64'(1));
        prev = c;
        pulses++;
      end
      if (bus0.frame_done) dones++;
      bus0.in_data = 48'(acc);
    end
    bus0.in_valid = 1'b0;
    checkOutput("zb_pulse_count", 64'(pulses), 64'(PAIRS));
    checkOutput("zb_accepted", 64'(acc), 64'(PAIRS));
    checkOutput("zb_frame_done", 64'(dones), 64'(1));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus0.start = 1'b0;
    bus0.in_valid = 1'b0;
    bus0.in_data = '0;
    HRESET = 1'b0;
    #1;
    HRESET = 1'b1;
    doReset();

    $display("[TB] basic frame, continuous input");
    runFrame(100, 1'b0, 1'b1, 0, 0);

    $display("[TB] random backpressure and underflow");
    runFrame(50, 1'b1, 1'b0, 0, 0);
    runFrame(65, 1'b1, 1'b0, 0, 0);

    $display("[TB] start pulsed mid-frame");
    runFrame(80, 1'b0, 1'b0, 6, 0);

    $display("[TB] reset mid-frame, then full frame");
    runFrame(100, 1'b0, 1'b1, 0, 9);
    runFrame(100, 1'b0, 1'b1, 0, 0);

    $display("[TB] zero blanking instance");
    zeroBlankFrame();

    checkOutput("scoreboard_drained", 64'(sbq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
